switch_router_ctrl: RTL and testbench
=====================================

SWITCH_ROUTER_CTRL -- requirements
Module: switch_router_ctrl

Interface
REQ-001 Parameter: DATA_W, 8, width of the routed data beat.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: sel  input  1  destination select (1 -> port c1, 0 -> port c0), sampled only in IDLE.
REQ-005 Port: in_valid  input  1  upstream beat valid.
REQ-006 Port: in_data  input  DATA_W  upstream beat data.
REQ-007 Port: in_last  input  1  beat ends the current packet.
REQ-008 Port: in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-009 Ports: c1_valid, c0_valid  output  1 each  output port beat valid.
REQ-010 Ports: c1_data, c0_data  output  DATA_W each  output port beat data.
REQ-011 Ports: c1_last, c0_last  output  1 each  output port end-of-packet.
REQ-012 Ports: c1_ready, c0_ready  input  1 each  downstream accepts a beat when valid & ready.
REQ-013 Ports: c1_pkts, c0_pkts  output  8 each  count of packets fully accepted toward each port.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, PKT1, PKT0.
REQ-016 IDLE: in_ready=0; if in_valid=1, destination latched and next state PKT1 (dest=1) or PKT0 (dest=0); else stay IDLE.
REQ-017 Routing decision latency SHALL be one cycle: the first beat is accepted no earlier than the cycle after in_valid is seen in IDLE.
REQ-018 PKTx: in_ready = ~cx_valid | cx_ready (one-entry output register per port, full throughput).
REQ-019 Accepted beat in PKTx SHALL load cx_data/cx_last from in_data/in_last and set cx_valid=1 on the next edge.
REQ-020 cx_valid SHALL clear on the edge after cx_valid & cx_ready unless a new beat loads the same cycle, in which case cx_valid stays 1 and the new beat is held.
REQ-021 Accepted beat with in_last=1 SHALL return the FSM to IDLE on the same edge and increment cx_pkts by 1.
REQ-022 cx_pkts SHALL wrap 255 -> 0 with no saturation or flag.
REQ-023 The non-selected port's register SHALL be untouched during a packet; it may finish draining a previously held beat.
REQ-024 Changes on sel outside IDLE SHALL be ignored; a packet is never split across ports.
REQ-025 Data SHALL never be duplicated: at most one of c1/c0 loads per cycle, and only on acceptance.
REQ-026 A single-beat packet (in_last on first beat) SHALL take IDLE -> PKTx -> IDLE with one accepted beat.
REQ-027 in_data/in_last SHALL pass unmodified; no reordering within a port.

Reset
REQ-028 With rst_n=0 at a rising edge: state=IDLE, c1_valid=c0_valid=0, c1_data=c0_data=0, c1_last=c0_last=0, c1_pkts=c0_pkts=0, busy=0, in_ready=0, round-robin pointer=0.
REQ-029 Reset mid-packet SHALL discard held and partial data; no cx_last is emitted for the aborted packet and its counter is not incremented.
REQ-030 Outputs SHALL be driven from registers or state only; no combinational path from cx_ready to cx_valid.

Configuration
REQ-031 Macro SWITCH_ROUTER_RR_EN: when defined, sel SHALL be ignored and destination taken from a 1-bit pointer, first packet after reset to c0, toggling on each accepted in_last beat.
REQ-032 Without SWITCH_ROUTER_RR_EN, destination SHALL be sel as sampled in IDLE and no pointer register SHALL exist.

Verification
REQ-033 Reset, sel=1, 3-beat packet 0xA1,0xA2,0xA3(last), c1_ready=1 -> c1 emits A1,A2,A3 on consecutive cycles, c1_last on A3, c1_pkts=1, c0_valid stays 0.
REQ-034 sel=0, 2-beat packet, c0_ready held 0 for 4 cycles then 1 -> in_ready=0 after first load, beats held in order, no loss, c0_pkts=1.
REQ-035 sel toggled 1->0 during a 4-beat packet started with sel=1 -> all 4 beats on c1, c0_pkts unchanged.
REQ-036 256 single-beat packets to c0 -> c0_pkts wraps to 0x00; each packet shows IDLE->PKT0->IDLE, busy pulses.
REQ-037 rst_n=0 after second beat of a 4-beat packet to c1 -> next cycle all outputs at reset values, c1_pkts=0; following packet routes normally.
REQ-038 With SWITCH_ROUTER_RR_EN, sel=1 constant, four single-beat packets -> destinations c0,c1,c0,c1; c0_pkts=2, c1_pkts=2.

Source files
------------

// File: rtl/switch_router_ctrl.sv
// -----------------------------------------------------------------------------
// switch_router_ctrl
//
// Purpose:
//   Packet router with one upstream stream and two downstream ports (c1, c0).
//   A packet's destination is decided in IDLE. From the following cycle, every
//   beat of that packet is steered into the chosen port's one-entry output
//   register, until the beat carrying in_last has been accepted.
//   Each output port keeps an 8-bit count of the packets fully accepted
//   toward it. This count wraps from 255 to 0.
//
// Optional feature (compile-time macro):
//   SWITCH_ROUTER_RR_EN - when defined, sel is ignored. The destination comes
//                         from a 1-bit round-robin pointer. The pointer starts
//                         at c0 after reset and toggles on every accepted last
//                         beat. When undefined, the destination is sel as
//                         sampled in IDLE, and no pointer register exists.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   sel        in   destination select (1 -> c1, 0 -> c0), used in IDLE only
//   in_valid   in   upstream beat valid
//   in_data    in   upstream beat data [DATA_W-1:0]
//   in_last    in   upstream end-of-packet
//   in_ready   out  upstream beat accepted when in_valid & in_ready
//   c1_*/c0_*  valid/data/last out, ready in: downstream ports
//   c1_pkts    out  packets fully accepted toward c1 (8 bit, wrapping)
//   c0_pkts    out  packets fully accepted toward c0 (8 bit, wrapping)
//   busy       out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module switch_router_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              c1_valid,
    output logic [DATA_W-1:0] c1_data,
    output logic              c1_last,
    input  logic              c1_ready,
    output logic              c0_valid,
    output logic [DATA_W-1:0] c0_data,
    output logic              c0_last,
    input  logic              c0_ready,
    output logic [7:0]        c1_pkts,
    output logic [7:0]        c0_pkts,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT1 = 2'd1,
        ST_PKT0 = 2'd2
    } state_e;

    state_e              state_q, state_d;

    logic                c1_valid_q, c1_valid_d;
    logic [DATA_W-1:0]   c1_data_q,  c1_data_d;
    logic                c1_last_q,  c1_last_d;
    logic [7:0]          c1_pkts_q,  c1_pkts_d;

    logic                c0_valid_q, c0_valid_d;
    logic [DATA_W-1:0]   c0_data_q,  c0_data_d;
    logic                c0_last_q,  c0_last_d;
    logic [7:0]          c0_pkts_q,  c0_pkts_d;

    logic                dest_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                load1_s;
    logic                load0_s;

`ifdef SWITCH_ROUTER_RR_EN
    logic                rr_ptr_q, rr_ptr_d;

    // Round-robin destination: sel is deliberately not used in this build.
    always_comb begin
        dest_s = rr_ptr_q;
    end
`else
    // Destination follows sel; it only matters while the FSM is IDLE.
    always_comb begin
        dest_s = sel;
    end
`endif

    // Upstream ready: only while in a packet, and only if the selected
    // output register is empty or is being drained this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_PKT1: in_ready_s = ~c1_valid_q | c1_ready;
            ST_PKT0: in_ready_s = ~c0_valid_q | c0_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Beat acceptance and per-port load strobes. At most one strobe can be
    // high, because the state selects exactly one port.
    always_comb begin
        accept_s = in_valid & in_ready_s;
        load1_s  = accept_s & (state_q == ST_PKT1);
        load0_s  = accept_s & (state_q == ST_PKT0);
    end

    // FSM next state. The routing decision is registered, so the first beat
    // cannot be accepted before the cycle after IDLE sees in_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = dest_s ? ST_PKT1 : ST_PKT0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT1, ST_PKT0: begin
                if (accept_s && in_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port c1 output register. A load wins over a drain, so a beat is never
    // lost when the register is drained and refilled in the same cycle.
    always_comb begin
        c1_valid_d = c1_valid_q;
        c1_data_d  = c1_data_q;
        c1_last_d  = c1_last_q;
        c1_pkts_d  = c1_pkts_q;
        if (load1_s) begin
            c1_valid_d = 1'b1;
            c1_data_d  = in_data;
            c1_last_d  = in_last;
            if (in_last) begin
                c1_pkts_d = c1_pkts_q + 8'd1;
            end else begin
                c1_pkts_d = c1_pkts_q;
            end
        end else if (c1_valid_q && c1_ready) begin
            c1_valid_d = 1'b0;
        end else begin
            c1_valid_d = c1_valid_q;
        end
    end

    // Port c0 output register. It has the same behaviour as c1.
    always_comb begin
        c0_valid_d = c0_valid_q;
        c0_data_d  = c0_data_q;
        c0_last_d  = c0_last_q;
        c0_pkts_d  = c0_pkts_q;
        if (load0_s) begin
            c0_valid_d = 1'b1;
            c0_data_d  = in_data;
            c0_last_d  = in_last;
            if (in_last) begin
                c0_pkts_d = c0_pkts_q + 8'd1;
            end else begin
                c0_pkts_d = c0_pkts_q;
            end
        end else if (c0_valid_q && c0_ready) begin
            c0_valid_d = 1'b0;
        end else begin
            c0_valid_d = c0_valid_q;
        end
    end

`ifdef SWITCH_ROUTER_RR_EN
    // Round-robin pointer toggles once per completed packet.
    always_comb begin
        if (accept_s && in_last) begin
            rr_ptr_d = ~rr_ptr_q;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register. It restarts at c0 on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // State and datapath registers. Reset drops any held or partial packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            c1_valid_q <= 1'b0;
            c1_data_q  <= {DATA_W{1'b0}};
            c1_last_q  <= 1'b0;
            c1_pkts_q  <= 8'd0;
            c0_valid_q <= 1'b0;
            c0_data_q  <= {DATA_W{1'b0}};
            c0_last_q  <= 1'b0;
            c0_pkts_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            c1_valid_q <= c1_valid_d;
            c1_data_q  <= c1_data_d;
            c1_last_q  <= c1_last_d;
            c1_pkts_q  <= c1_pkts_d;
            c0_valid_q <= c0_valid_d;
            c0_data_q  <= c0_data_d;
            c0_last_q  <= c0_last_d;
            c0_pkts_q  <= c0_pkts_d;
        end
    end

    // Output drive. Everything is registered, except in_ready, which must
    // see same-cycle downstream ready to sustain full throughput.
    always_comb begin
        in_ready = in_ready_s;
        c1_valid = c1_valid_q;
        c1_data  = c1_data_q;
        c1_last  = c1_last_q;
        c0_valid = c0_valid_q;
        c0_data  = c0_data_q;
        c0_last  = c0_last_q;
        c1_pkts  = c1_pkts_q;
        c0_pkts  = c0_pkts_q;
        busy     = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_switch_router_ctrl.sv
// -----------------------------------------------------------------------------
// tb_switch_router_ctrl
//
// Self-checking bench for switch_router_ctrl.
// A packet-level reference model tracks four things: whether a packet is
// open, the packet's destination, each port's held beat, and each port's
// packet count. A negedge compare process checks every DUT output against
// this model. Directed scenarios add literal expectations, and a randomized
// phase exercises gaps and backpressure. Builds with SWITCH_ROUTER_RR_EN run
// the round-robin scenario instead of the sel-based directed ones.
// -----------------------------------------------------------------------------
module tb_switch_router_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       c1_valid, c0_valid;
    logic [7:0] c1_data,  c0_data;
    logic       c1_last,  c0_last;
    logic       c1_ready, c0_ready;
    logic [7:0] c1_pkts,  c0_pkts;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit rand_ready = 1'b0;

    logic [7:0] c1_seen[$];
    logic [7:0] c0_seen[$];

    switch_router_ctrl #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready),
        .c1_valid(c1_valid), .c1_data(c1_data), .c1_last(c1_last), .c1_ready(c1_ready),
        .c0_valid(c0_valid), .c0_data(c0_data), .c0_last(c0_last), .c0_ready(c0_ready),
        .c1_pkts(c1_pkts), .c0_pkts(c0_pkts), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_busy: a packet is open. m_dest: its port (1 = c1).
    // Index 1 of each array is port c1, index 0 is port c0.
    logic       m_busy, m_dest, m_ptr;
    logic       m_v[2];
    logic [7:0] m_d[2];
    logic       m_l[2];
    logic [7:0] m_pk[2];
    logic       rdy[2];
    logic       m_rdy, m_acc;

    assign rdy[0] = c0_ready;
    assign rdy[1] = c1_ready;
    assign m_rdy  = m_busy && (!m_v[m_dest] || rdy[m_dest]);
    assign m_acc  = m_rdy && in_valid;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_dest <= 1'b0;
            m_ptr  <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_v[p]  <= 1'b0;
                m_d[p]  <= 8'd0;
                m_l[p]  <= 1'b0;
                m_pk[p] <= 8'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (m_acc && (m_dest == p[0])) begin
                    m_v[p] <= 1'b1;
                    m_d[p] <= in_data;
                    m_l[p] <= in_last;
                    if (in_last) m_pk[p] <= m_pk[p] + 8'd1;
                end else if (m_v[p] && rdy[p]) begin
                    m_v[p] <= 1'b0;
                end
            end
            if (m_acc && in_last) begin
                m_busy <= 1'b0;
                m_ptr  <= ~m_ptr;
            end else if (!m_busy && in_valid) begin
                m_busy <= 1'b1;
`ifdef SWITCH_ROUTER_RR_EN
                m_dest <= m_ptr;
`else
                m_dest <= sel;
`endif
            end
        end
    end

    // Record the beats actually delivered on each port.
    always @(posedge clk) begin
        if (rst_n && c1_valid && c1_ready) c1_seen.push_back(c1_data);
        if (rst_n && c0_valid && c0_ready) c0_seen.push_back(c0_data);
    end

    // Compare the DUT against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
            chk("busy",     {31'd0, busy},     {31'd0, m_busy});
            chk("c1_valid", {31'd0, c1_valid}, {31'd0, m_v[1]});
            chk("c0_valid", {31'd0, c0_valid}, {31'd0, m_v[0]});
            chk("c1_pkts",  {24'd0, c1_pkts},  {24'd0, m_pk[1]});
            chk("c0_pkts",  {24'd0, c0_pkts},  {24'd0, m_pk[0]});
            if (m_v[1] || !m_busy && !m_v[1] && m_d[1] == 8'd0) begin
                chk("c1_data", {24'd0, c1_data}, {24'd0, m_d[1]});
                chk("c1_last", {31'd0, c1_last}, {31'd0, m_l[1]});
            end
            if (m_v[0] || !m_busy && !m_v[0] && m_d[0] == 8'd0) begin
                chk("c0_data", {24'd0, c0_data}, {24'd0, m_d[0]});
                chk("c0_last", {31'd0, c0_last}, {31'd0, m_l[0]});
            end
        end
    end

    // Random downstream backpressure.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            c1_ready = ($urandom_range(0, 3) != 0);
            c0_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    // Send one packet of len beats, with data base+0, base+1, ...
    // toggle_after: flip sel after that many accepted beats (0 = never).
    // abort_after:  assert reset instead of sending beat number abort_after.
    task automatic send_pkt(input logic s, input int len, input logic [7:0] base,
                            input int toggle_after, input int abort_after, input bit gaps);
        sel = s;
        for (int b = 0; b < len; b++) begin
            int  t;
            bit  acc;
            if (b == abort_after) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                rst_n    = 1'b0;
                cycle();
                rst_n    = 1'b1;
                return;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cycle();
            end
            in_valid = 1'b1;
            in_data  = base + b[7:0];
            in_last  = (b == len - 1);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 200) begin
                #1;
                acc = in_ready;
                cycle();
                t++;
            end
            if (!acc) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (b + 1 == toggle_after) sel = ~s;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
        c1_ready = 1'b1; c0_ready = 1'b1;
        cycle();
        cycle();
        chk_en = 1'b1;
        rst_n = 1'b1;
        chk("rst_c1_pkts", {24'd0, c1_pkts}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

`ifndef SWITCH_ROUTER_RR_EN
        // Three-beat packet to c1 with ready held high.
        c1_seen.delete();
        send_pkt(1'b1, 3, 8'hA1, 0, -1, 1'b0);
        repeat (3) cycle();
        chk("t1_c1_pkts", {24'd0, c1_pkts}, 32'd1);
        chk("t1_c0_pkts", {24'd0, c0_pkts}, 32'd0);
        chk("t1_c1_n", c1_seen.size(), 32'd3);
        if (c1_seen.size() == 3) begin
            chk("t1_b0", {24'd0, c1_seen[0]}, 32'hA1);
            chk("t1_b2", {24'd0, c1_seen[2]}, 32'hA3);
        end

        // Two-beat packet to c0 under 4 cycles of backpressure.
        c0_seen.delete();
        c0_ready = 1'b0;
        fork
            send_pkt(1'b0, 2, 8'hB1, 0, -1, 1'b0);
            begin repeat (4) cycle(); c0_ready = 1'b1; end
        join
        repeat (3) cycle();
        chk("t2_c0_pkts", {24'd0, c0_pkts}, 32'd1);
        chk("t2_c0_n", c0_seen.size(), 32'd2);
        if (c0_seen.size() == 2) begin
            chk("t2_b0", {24'd0, c0_seen[0]}, 32'hB1);
            chk("t2_b1", {24'd0, c0_seen[1]}, 32'hB2);
        end

        // sel flipped mid-packet: all four beats must stay on c1.
        c1_seen.delete();
        send_pkt(1'b1, 4, 8'hC1, 1, -1, 1'b0);
        repeat (3) cycle();
        chk("t3_c1_pkts", {24'd0, c1_pkts}, 32'd2);
        chk("t3_c0_pkts", {24'd0, c0_pkts}, 32'd1);
        chk("t3_c1_n", c1_seen.size(), 32'd4);

        // 256 single-beat packets to c0: the counter wraps back to zero.
        do_reset();
        c0_seen.delete();
        for (int i = 0; i < 256; i++) begin
            send_pkt(1'b0, 1, i[7:0], 0, -1, 1'b0);
            if (i == 254) chk("t4_c0_255", {24'd0, c0_pkts}, 32'd255);
        end
        repeat (2) cycle();
        chk("t4_c0_wrap", {24'd0, c0_pkts}, 32'd0);
        chk("t4_c0_n", c0_seen.size(), 32'd256);

        // Reset after the second beat of a four-beat packet to c1.
        do_reset();
        send_pkt(1'b1, 4, 8'hD1, 0, 2, 1'b0);
        chk("t5_c1_pkts", {24'd0, c1_pkts}, 32'd0);
        chk("t5_c1_valid", {31'd0, c1_valid}, 32'd0);
        chk("t5_c1_data", {24'd0, c1_data}, 32'd0);
        send_pkt(1'b1, 2, 8'hE1, 0, -1, 1'b0);
        repeat (3) cycle();
        chk("t5_after", {24'd0, c1_pkts}, 32'd1);
`else
        // Round robin: sel stays 1, yet destinations alternate c0, c1, c0, c1.
        c1_seen.delete();
        c0_seen.delete();
        for (int i = 0; i < 4; i++) send_pkt(1'b1, 1, 8'h10 + i[7:0], 0, -1, 1'b0);
        repeat (3) cycle();
        chk("rr_c0_pkts", {24'd0, c0_pkts}, 32'd2);
        chk("rr_c1_pkts", {24'd0, c1_pkts}, 32'd2);
        if (c0_seen.size() == 2 && c1_seen.size() == 2) begin
            chk("rr_c0_first", {24'd0, c0_seen[0]}, 32'h10);
            chk("rr_c1_first", {24'd0, c1_seen[0]}, 32'h11);
        end else begin
            chk("rr_split", c0_seen.size(), 32'd2);
        end
`endif

        // Random packets with gaps and backpressure.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_pkt($urandom_range(0, 1), $urandom_range(1, 5), 8'($urandom),
                     $urandom_range(0, 2), -1, 1'b1);
        end
        rand_ready = 1'b0;
        c1_ready = 1'b1;
        c0_ready = 1'b1;
        repeat (5) cycle();
        chk("drain_c1", {31'd0, c1_valid}, 32'd0);
        chk("drain_c0", {31'd0, c0_valid}, 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
